// File: rtl/ct_idu_ir_vreg_alloc_buf.sv
// IR-stage vector physical register allocation buffer.
// Holds up to four free vregs prefetched from the RTU vreg free list. It hands
// them, in entry order, to the requesting IR instructions in instruction order.
//
// Handshake: RTU slot N presents (rtu_idu_alloc_vregN, rtu_idu_alloc_vregN_vld).
// IDU answers with idu_rtu_ir_vregN_alloc_vld whenever entry N is empty. In that
// same cycle the RTU removes the preg from its free list, and the entry captures
// it at the clock edge. Valid/ready pairing therefore reduces to
// take = vld & ~entry_vld. It is independent of stall and flush.
module ct_idu_ir_vreg_alloc_buf (
   input  logic       cpuclk,
   input  logic       cpurst,
   input  logic [5:0] rtu_idu_alloc_vreg0,
   input  logic [5:0] rtu_idu_alloc_vreg1,
   input  logic [5:0] rtu_idu_alloc_vreg2,
   input  logic [5:0] rtu_idu_alloc_vreg3,
   input  logic       rtu_idu_alloc_vreg0_vld,
   input  logic       rtu_idu_alloc_vreg1_vld,
   input  logic       rtu_idu_alloc_vreg2_vld,
   input  logic       rtu_idu_alloc_vreg3_vld,
   input  logic       ir_inst0_vreg_req,
   input  logic       ir_inst1_vreg_req,
   input  logic       ir_inst2_vreg_req,
   input  logic       ir_inst3_vreg_req,
   input  logic       ir_stall,
   input  logic       rtu_idu_flush_fe,
   output logic [5:0] ir_inst0_vreg,
   output logic [5:0] ir_inst1_vreg,
   output logic [5:0] ir_inst2_vreg,
   output logic [5:0] ir_inst3_vreg,
   output logic       ir_vreg_not_enough,
   output logic       idu_rtu_ir_vreg0_alloc_vld,
   output logic       idu_rtu_ir_vreg1_alloc_vld,
   output logic       idu_rtu_ir_vreg2_alloc_vld,
   output logic       idu_rtu_ir_vreg3_alloc_vld,
   output logic       idu_rtu_ir_vreg_alloc_gateclk_vld
);

   logic [3:0] r_vld;
   logic [5:0] r_preg [4];

   logic [5:0] w_offer [4];
   logic [3:0] w_offer_vld;
   logic [3:0] w_req;
   logic [3:0] w_take;
   logic [3:0] w_clr;
   logic [2:0] w_req_cnt;
   logic [2:0] w_vld_cnt;
   logic [2:0] w_req_rank [4];
   logic [2:0] w_vld_rank [4];
   logic [5:0] w_inst_vreg [4];
   logic       w_not_enough;
   logic       w_consume;

   assign w_offer[0]  = rtu_idu_alloc_vreg0;
   assign w_offer[1]  = rtu_idu_alloc_vreg1;
   assign w_offer[2]  = rtu_idu_alloc_vreg2;
   assign w_offer[3]  = rtu_idu_alloc_vreg3;
   assign w_offer_vld = {rtu_idu_alloc_vreg3_vld, rtu_idu_alloc_vreg2_vld,
                         rtu_idu_alloc_vreg1_vld, rtu_idu_alloc_vreg0_vld};
   assign w_req       = {ir_inst3_vreg_req, ir_inst2_vreg_req,
                         ir_inst1_vreg_req, ir_inst0_vreg_req};

   // An empty entry always accepts its RTU slot's offer.
   assign w_take = ~r_vld & w_offer_vld;

   // Prefix counts: rank of each requester among requesters, and of each
   // valid entry among valid entries; the totals fall out of the same scan.
   always_comb begin
      w_req_cnt = 3'd0;
      w_vld_cnt = 3'd0;
      for (int i = 0; i < 4; i++) begin
         w_req_rank[i] = w_req_cnt;
         w_vld_rank[i] = w_vld_cnt;
         w_req_cnt     = w_req_cnt + {2'b00, w_req[i]};
         w_vld_cnt     = w_vld_cnt + {2'b00, r_vld[i]};
      end
   end

   assign w_not_enough = (w_req_cnt > w_vld_cnt);
   assign w_consume    = ~ir_stall & ~rtu_idu_flush_fe & ~w_not_enough &
                         (w_req_cnt != 3'd0);

   // Requester of rank k picks the valid entry of rank k; others drive zero.
   always_comb begin
      for (int n = 0; n < 4; n++) begin
         w_inst_vreg[n] = 6'd0;
         for (int e = 0; e < 4; e++) begin
            if (w_req[n] && r_vld[e] && (w_vld_rank[e] == w_req_rank[n])) begin
               w_inst_vreg[n] = r_preg[e];
            end
         end
      end
   end

   // The lowest req_cnt valid entries are the ones handed out; they clear only on a full consume.
   always_comb begin
      for (int e = 0; e < 4; e++) begin
         w_clr[e] = w_consume & r_vld[e] & (w_vld_rank[e] < w_req_cnt);
      end
   end

   // Entry state: take fills an empty entry, consume empties a full one.
   always_ff @(posedge cpuclk or posedge cpurst) begin
      if (cpurst) begin
         r_vld <= 4'b0000;
         for (int e = 0; e < 4; e++) begin
            r_preg[e] <= 6'd0;
         end
      end else begin
         for (int e = 0; e < 4; e++) begin
            if (w_take[e]) begin
               r_vld[e]  <= 1'b1;
               r_preg[e] <= w_offer[e];
            end else if (w_clr[e]) begin
               r_vld[e]  <= 1'b0;
            end
         end
      end
   end

   assign ir_inst0_vreg                     = w_inst_vreg[0];
   assign ir_inst1_vreg                     = w_inst_vreg[1];
   assign ir_inst2_vreg                     = w_inst_vreg[2];
   assign ir_inst3_vreg                     = w_inst_vreg[3];
   assign ir_vreg_not_enough                = w_not_enough;
   assign idu_rtu_ir_vreg0_alloc_vld        = w_take[0];
   assign idu_rtu_ir_vreg1_alloc_vld        = w_take[1];
   assign idu_rtu_ir_vreg2_alloc_vld        = w_take[2];
   assign idu_rtu_ir_vreg3_alloc_vld        = w_take[3];
   assign idu_rtu_ir_vreg_alloc_gateclk_vld = |w_take;

endmodule

// File: tb/tb_ct_idu_ir_vreg_alloc_buf.sv
// Testbench for ct_idu_ir_vreg_alloc_buf: directed scenarios plus random traffic
// against a queue-based reference model of the allocation buffer.
module tb_ct_idu_ir_vreg_alloc_buf;

   logic       cpuclk;
   logic       cpurst;
   logic [5:0] offer [4];
   logic [3:0] ovld;
   logic [3:0] req;
   logic       ir_stall;
   logic       flush;
   logic [5:0] vreg [4];
   logic       not_enough;
   logic [3:0] alloc;
   logic       gateclk;

   int n_chk  = 0;
   int n_pass = 0;

   // reference model state
   bit         m_vld [4];
   logic [5:0] m_preg [4];

   // expectations for the current cycle
   logic [3:0] e_alloc;
   logic       e_ne;
   logic [5:0] e_vreg [4];
   bit         e_pick [4];
   bit         e_consume;

   ct_idu_ir_vreg_alloc_buf dut (
      .cpuclk                            (cpuclk),
      .cpurst                            (cpurst),
      .rtu_idu_alloc_vreg0               (offer[0]),
      .rtu_idu_alloc_vreg1               (offer[1]),
      .rtu_idu_alloc_vreg2               (offer[2]),
      .rtu_idu_alloc_vreg3               (offer[3]),
      .rtu_idu_alloc_vreg0_vld           (ovld[0]),
      .rtu_idu_alloc_vreg1_vld           (ovld[1]),
      .rtu_idu_alloc_vreg2_vld           (ovld[2]),
      .rtu_idu_alloc_vreg3_vld           (ovld[3]),
      .ir_inst0_vreg_req                 (req[0]),
      .ir_inst1_vreg_req                 (req[1]),
      .ir_inst2_vreg_req                 (req[2]),
      .ir_inst3_vreg_req                 (req[3]),
      .ir_stall                          (ir_stall),
      .rtu_idu_flush_fe                  (flush),
      .ir_inst0_vreg                     (vreg[0]),
      .ir_inst1_vreg                     (vreg[1]),
      .ir_inst2_vreg                     (vreg[2]),
      .ir_inst3_vreg                     (vreg[3]),
      .ir_vreg_not_enough                (not_enough),
      .idu_rtu_ir_vreg0_alloc_vld        (alloc[0]),
      .idu_rtu_ir_vreg1_alloc_vld        (alloc[1]),
      .idu_rtu_ir_vreg2_alloc_vld        (alloc[2]),
      .idu_rtu_ir_vreg3_alloc_vld        (alloc[3]),
      .idu_rtu_ir_vreg_alloc_gateclk_vld (gateclk)
   );

   // clock
   initial cpuclk = 1'b0;
   always #5 cpuclk = ~cpuclk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
   endtask

   // Reference: list valid entries in order, hand them out to requesters in order.
   task automatic compute_exp();
      int q[$];
      int nreq;
      q    = {};
      nreq = 0;
      for (int e = 0; e < 4; e++) begin
         if (m_vld[e]) q.push_back(e);
         e_pick[e] = 0;
      end
      for (int n = 0; n < 4; n++) if (req[n]) nreq++;
      e_ne = (nreq > q.size());
      for (int n = 0; n < 4; n++) begin
         e_vreg[n] = 6'd0;
         if (req[n] && q.size() > 0) begin
            int e;
            e = q.pop_front();
            e_vreg[n] = m_preg[e];
            e_pick[e] = 1;
         end
      end
      for (int n = 0; n < 4; n++) e_alloc[n] = !m_vld[n] && ovld[n];
      e_consume = !ir_stall && !flush && !e_ne && (nreq > 0);
   endtask

   task automatic half();
      @(negedge cpuclk);
      compute_exp();
      chk("alloc", {28'd0, alloc}, {28'd0, e_alloc});
      chk("gateclk", {31'd0, gateclk}, {31'd0, |e_alloc});
      chk("not_enough", {31'd0, not_enough}, {31'd0, e_ne});
      if (!e_ne) begin
         for (int n = 0; n < 4; n++) chk($sformatf("vreg%0d", n), {26'd0, vreg[n]}, {26'd0, e_vreg[n]});
      end
   endtask

   task automatic edge_step();
      @(posedge cpuclk);
      for (int e = 0; e < 4; e++) begin
         if (e_alloc[e]) begin
            m_vld[e]  = 1;
            m_preg[e] = offer[e];
         end else if (e_consume && e_pick[e]) begin
            m_vld[e] = 0;
         end
      end
      #1;
   endtask

   task automatic cyc();
      half();
      edge_step();
   endtask

   task automatic drive(input logic [5:0] o0, input logic [5:0] o1, input logic [5:0] o2,
                        input logic [5:0] o3, input logic [3:0] ov, input logic [3:0] rq,
                        input logic st, input logic fl);
      offer[0] = o0; offer[1] = o1; offer[2] = o2; offer[3] = o3;
      ovld = ov; req = rq; ir_stall = st; flush = fl;
   endtask

   task automatic model_reset();
      for (int e = 0; e < 4; e++) begin
         m_vld[e]  = 0;
         m_preg[e] = 6'd0;
      end
   endtask

   initial begin
      model_reset();
      cpurst = 1'b1;
      drive(0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0);
      #12 cpurst = 1'b0;
      @(posedge cpuclk); #1;

      // reset state: empty buffer, no requests, no offers
      cyc();
      // nonzero request on empty buffer
      drive(0, 0, 0, 0, 4'b0000, 4'b0001, 0, 0);
      half(); chk("rst_ne", {31'd0, not_enough}, 32'd1); edge_step();

      // reset then fill
      drive(5, 6, 7, 8, 4'b1111, 4'b0000, 0, 0);
      half(); chk("fill_alloc", {28'd0, alloc}, 32'hf); edge_step();
      half(); chk("full_alloc", {28'd0, alloc}, 32'h0); edge_step();

      // in-order assignment: inst1 and inst3 request
      drive(0, 0, 0, 0, 4'b0000, 4'b1010, 0, 0);
      half();
      chk("io_v1", {26'd0, vreg[1]}, 32'd5);
      chk("io_v3", {26'd0, vreg[3]}, 32'd6);
      chk("io_v0", {26'd0, vreg[0]}, 32'd0);
      chk("io_v2", {26'd0, vreg[2]}, 32'd0);
      edge_step();
      drive(20, 21, 22, 23, 4'b1111, 4'b0000, 0, 0);
      half(); chk("io_refill", {28'd0, alloc}, 32'h3); edge_step();

      // async reset between edges with full buffer
      drive(1, 2, 3, 4, 4'b1010, 4'b1111, 0, 0);
      cpurst = 1'b1;
      #1;
      chk("arst_alloc", {28'd0, alloc}, 32'ha);
      chk("arst_ne", {31'd0, not_enough}, 32'd1);
      model_reset();
      #1 cpurst = 1'b0;
      drive(0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0);
      cyc();

      // not enough: only entry 2 valid with 9
      drive(0, 0, 9, 0, 4'b0100, 4'b0000, 0, 0);
      cyc();
      drive(0, 0, 0, 0, 4'b0000, 4'b0011, 0, 0);
      half(); chk("ne_1", {31'd0, not_enough}, 32'd1); edge_step();
      drive(10, 0, 0, 0, 4'b0001, 4'b0011, 0, 0);
      half(); chk("ne_2", {31'd0, not_enough}, 32'd1); chk("ne_take", {28'd0, alloc}, 32'h1); edge_step();
      drive(0, 0, 0, 0, 4'b0000, 4'b0011, 0, 0);
      half();
      chk("ne_ok", {31'd0, not_enough}, 32'd0);
      chk("ne_v0", {26'd0, vreg[0]}, 32'd10);
      chk("ne_v1", {26'd0, vreg[1]}, 32'd9);
      edge_step();

      // stall / flush: no consumption, takes still proceed
      drive(30, 31, 32, 33, 4'b1111, 4'b0000, 0, 0);
      cyc();
      drive(0, 0, 0, 0, 4'b0000, 4'b1111, 1, 0);
      cyc();
      drive(0, 0, 0, 0, 4'b0000, 4'b1111, 0, 1);
      cyc();
      drive(0, 0, 0, 0, 4'b0000, 4'b1111, 1, 1);
      cyc();
      drive(0, 0, 0, 0, 4'b0000, 4'b0011, 0, 0);
      cyc();
      drive(40, 41, 42, 43, 4'b1111, 4'b0001, 0, 1);
      half(); chk("fl_take", {28'd0, alloc}, 32'h3); edge_step();
      drive(0, 0, 0, 0, 4'b0000, 4'b1111, 1, 0);
      half();
      chk("fl_v0", {26'd0, vreg[0]}, 32'd40);
      chk("fl_v1", {26'd0, vreg[1]}, 32'd41);
      chk("fl_v2", {26'd0, vreg[2]}, 32'd32);
      chk("fl_v3", {26'd0, vreg[3]}, 32'd33);
      edge_step();

      // refill latency on entry 0
      drive(12, 0, 0, 0, 4'b0001, 4'b0001, 0, 0);
      half(); chk("rl_t0", {28'd0, alloc}, 32'h0); chk("rl_v0", {26'd0, vreg[0]}, 32'd40); edge_step();
      drive(12, 0, 0, 0, 4'b0001, 4'b0000, 0, 0);
      half(); chk("rl_t1", {28'd0, alloc}, 32'h1); edge_step();
      drive(12, 0, 0, 0, 4'b0001, 4'b0001, 1, 0);
      half(); chk("rl_t2", {28'd0, alloc}, 32'h0); chk("rl_v12", {26'd0, vreg[0]}, 32'd12); edge_step();

      // random traffic
      for (int i = 0; i < 400; i++) begin
         logic [3:0] rq;
         rq = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 3) == 0) rq = 4'b0000;
         drive(6'($urandom), 6'($urandom), 6'($urandom), 6'($urandom),
               4'($urandom_range(0, 15)), rq,
               ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0));
         if ($urandom_range(0, 99) == 0) begin
            cpurst = 1'b1;
            #1;
            chk("rnd_arst_alloc", {28'd0, alloc}, {28'd0, ovld});
            model_reset();
            #1 cpurst = 1'b0;
         end
         cyc();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/ct_idu_ir_vreg_alloc_buf.md
# ct_idu_ir_vreg_alloc_buf

IDU-side vector physical register allocation buffer at the IR stage. Consumes the four-slot free-vreg offer that the RTU vreg PST drives on `rtu_idu_alloc_vreg0..3` and returns per-slot take handshakes. Holds up to four prefetched free vregs and hands them in order to up to four IR instructions per cycle. Stalls IR when the buffer cannot cover the request count.

## Interface
- No parameters; slot count 4 and preg width 6 are fixed.
- `cpuclk` input 1: core clock.
- `cpurst` input 1: asynchronous reset, active-high.
- `rtu_idu_alloc_vreg0..3` input 6 each: free vreg offered in RTU slot N.
- `rtu_idu_alloc_vreg0..3_vld` input 1 each: slot N offer valid.
- `ir_inst0..3_vreg_req` input 1 each: IR instruction N needs a destination vreg this cycle.
- `ir_stall` input 1: IR stage held by another source; no consumption.
- `rtu_idu_flush_fe` input 1: front-end flush; no consumption this cycle.
- `ir_inst0..3_vreg` output 6 each: vreg assigned to instruction N (combinational).
- `ir_vreg_not_enough` output 1: fewer valid entries than requests (combinational).
- `idu_rtu_ir_vreg0..3_alloc_vld` output 1 each: IDU takes RTU slot N this cycle (combinational).
- `idu_rtu_ir_vreg_alloc_gateclk_vld` output 1: OR of the four alloc_vld bits.

## Operation
- State: four entries, each with `vld` (1 bit) and `preg` (6 bits). On reset all `vld`=0 and all `preg`=0.
- Take handshake:
  - `idu_rtu_ir_vregN_alloc_vld = ~entry_vld[N] & rtu_idu_alloc_vregN_vld`.
  - On that cycle's edge, entry N captures `rtu_idu_alloc_vregN` and sets `vld`.
  - Flush does not block the take.
  - RTU treats an asserted alloc_vld as removal of that preg from its free list.
- Request count: `req_cnt` = popcount of `ir_inst*_vreg_req` (0..4). `vld_cnt` = popcount of `entry_vld` (0..4).
- `ir_vreg_not_enough = (req_cnt > vld_cnt)`.
- Assignment: the k-th requesting instruction, in instruction-index order, gets the k-th valid entry, in entry-index order.
  - `ir_instN_vreg` = that entry's `preg`.
  - Non-requesting instructions output 6'b0.
  - If not_enough, outputs are still driven but are don't-care.
- Consume condition: `~ir_stall & ~rtu_idu_flush_fe & ~ir_vreg_not_enough & (req_cnt != 0)`. Only when true do the assigned entries clear `vld` at the clock edge.
- All-or-nothing: there is no partial consumption. When not_enough, no entry changes except through the take path.
- An entry consumed in cycle t is empty in t+1. It may take in t+1 and is valid again in t+2. An entry never takes and is consumed in the same cycle; this holds because take requires the entry to be empty.
- Preg values are never duplicated. Each captured preg leaves the buffer exactly once, through consumption.

## Timing
- Take-to-valid latency: 1 cycle.
- Consume-to-refill: at least 2 cycles for the same entry.
- Outputs `ir_inst*_vreg`, `ir_vreg_not_enough`, and the alloc_vld bits are combinational from the registered state and inputs.
- After reset deassertion: all alloc_vld bits follow the RTU valids directly, since all entries are empty. `ir_vreg_not_enough`=1 for any nonzero request until entries fill.
- Reset asserted mid-operation: entries clear immediately (async), alloc_vld recomputes from empty entries, and buffered pregs are lost. RTU is reset by the same `cpurst`, so its free list rebuilds consistently.
- Simultaneous `ir_stall` and flush: identical to either alone (no consume). Takes proceed.
- `req_cnt`=0: no consume, and `ir_vreg_not_enough`=0 even when the buffer is empty.

## Test plan
- Reset then fill:
  - Stimulus: offers 5, 6, 7, 8 all valid.
  - Cycle 0: alloc_vld = 4'b1111.
  - Cycle 1: all entries valid and alloc_vld = 4'b0000.
- In-order assignment:
  - Stimulus: entries {5, 6, 7, 8} full; requests from inst1 and inst3.
  - Response: `ir_inst1_vreg`=5, `ir_inst3_vreg`=6, inst0/inst2 = 0.
  - Next cycle: entries 0 and 1 empty, alloc_vld[1:0] asserted if RTU offers are valid.
- Not enough:
  - Stimulus: only entry 2 valid (preg 9); requests from inst0 and inst1.
  - Response: `ir_vreg_not_enough`=1 and entry 2 stays valid.
  - After entry 0 fills with 10, the retried requests give inst0=10, inst1=9.
- Stall/flush:
  - Stimulus: full buffer, 4 requests, `ir_stall`=1.
  - Response: no consumption.
  - Repeat with `rtu_idu_flush_fe`=1: same result. Takes into empty slots still occur.
- Refill latency:
  - Stimulus: consume entry 0 at cycle t; RTU slot 0 offers 12 continuously.
  - Response: alloc_vld0 at t+1, entry 0 valid with 12 at t+2, and alloc_vld0 = 0 from t+2.
- Async reset mid-run:
  - Stimulus: assert `cpurst` between edges with the buffer full.
  - Response: all vld clear immediately, alloc_vld follows RTU offers, and not_enough=1 for any request.
